// File: rtl/circuit2_hlsm.sv
// Multi-cycle scheduled datapath for d/e/f compare-select-shift.
// It uses one shared add/sub unit, one signed comparator and one bidirectional shifter.
module circuit2_hlsm #(
    parameter int DATAWIDTH = 32
) (
    input  logic                 Clk,
    input  logic                 Rst,
    input  logic                 Start,
    input  logic [DATAWIDTH-1:0] a,
    input  logic [DATAWIDTH-1:0] b,
    input  logic [DATAWIDTH-1:0] c,
    output logic                 Done,
    output logic [DATAWIDTH-1:0] z,
    output logic [DATAWIDTH-1:0] x
);

    typedef enum logic [3:0] {
        WAIT, S1, S2, S3, S4, S5, S6, S7, FINAL
    } state_t;

    state_t state_q, state_d;

    logic [DATAWIDTH-1:0] ra_q, rb_q, rc_q, ra_d, rb_d, rc_d;
    logic [DATAWIDTH-1:0] d_q, e_q, f_q, g_q, h_q, d_d, e_d, f_d, g_d, h_d;
    logic [DATAWIDTH-1:0] x_q, z_q, x_d, z_d;
    logic                 dlte_q, deq_q, dlte_d, deq_d;

    // Shared functional units; operand steering depends only on the current state.
    logic [DATAWIDTH-1:0] alu_b, alu_res;
    logic                 cmp_lt, cmp_eq;
    logic                 sh_left, sh_amt;
    logic [DATAWIDTH-1:0] sh_in, sh_res;

    always_comb begin
        alu_b   = (state_q == S2) ? rc_q : rb_q;
        alu_res = (state_q == S3) ? (ra_q - alu_b) : (ra_q + alu_b);
        cmp_lt  = $signed(d_q) < $signed(e_q);
        cmp_eq  = (d_q == e_q);
        sh_left = (state_q == S6);
        sh_in   = sh_left ? g_q : h_q;
        sh_amt  = sh_left ? dlte_q : deq_q;
        sh_res  = sh_left ? (sh_in << sh_amt) : (sh_in >> sh_amt);
    end

    always_comb begin
        state_d = state_q;
        ra_d    = ra_q;
        rb_d    = rb_q;
        rc_d    = rc_q;
        d_d     = d_q;
        e_d     = e_q;
        f_d     = f_q;
        g_d     = g_q;
        h_d     = h_q;
        dlte_d  = dlte_q;
        deq_d   = deq_q;
        x_d     = x_q;
        z_d     = z_q;
        case (state_q)
            WAIT: begin
                if (Start) begin
                    ra_d    = a;
                    rb_d    = b;
                    rc_d    = c;
                    state_d = S1;
                end
            end
            S1: begin
                d_d     = alu_res;
                state_d = S2;
            end
            S2: begin
                e_d     = alu_res;
                state_d = S3;
            end
            S3: begin
                f_d     = alu_res;
                state_d = S4;
            end
            S4: begin
                dlte_d  = cmp_lt;
                deq_d   = cmp_eq;
                state_d = S5;
            end
            S5: begin
                g_d     = dlte_q ? d_q : e_q;
                state_d = S6;
            end
            S6: begin
                h_d     = deq_q ? g_q : f_q;
                x_d     = sh_res;
                state_d = S7;
            end
            S7: begin
                z_d     = sh_res;
                state_d = FINAL;
            end
            FINAL:   state_d = WAIT;
            default: state_d = WAIT;
        endcase
    end

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state_q <= WAIT;
            ra_q    <= '0;
            rb_q    <= '0;
            rc_q    <= '0;
            d_q     <= '0;
            e_q     <= '0;
            f_q     <= '0;
            g_q     <= '0;
            h_q     <= '0;
            dlte_q  <= 1'b0;
            deq_q   <= 1'b0;
            x_q     <= '0;
            z_q     <= '0;
        end else begin
            state_q <= state_d;
            ra_q    <= ra_d;
            rb_q    <= rb_d;
            rc_q    <= rc_d;
            d_q     <= d_d;
            e_q     <= e_d;
            f_q     <= f_d;
            g_q     <= g_d;
            h_q     <= h_d;
            dlte_q  <= dlte_d;
            deq_q   <= deq_d;
            x_q     <= x_d;
            z_q     <= z_d;
        end
    end

    // Done is a pure state decode, so the ninth cycle counting the Start cycle carries it.
    assign Done = (state_q == FINAL);
    assign x    = x_q;
    assign z    = z_q;

endmodule

// File: tb/tb_circuit2_hlsm.sv
// Randomized self-checking bench for circuit2_hlsm against an arithmetic reference model.
module tb_circuit2_hlsm;

    logic        Clk = 1'b0;
    logic        Rst;
    logic        Start;
    logic [31:0] a, b, c;
    logic        Done;
    logic [31:0] z, x;

    int          checks   = 0;
    int          failures = 0;
    logic [31:0] exp_x    = '0;
    logic [31:0] exp_z    = '0;

    always #5 Clk = ~Clk;

    circuit2_hlsm #(.DATAWIDTH(32)) dut (
        .Clk  (Clk),
        .Rst  (Rst),
        .Start(Start),
        .a    (a),
        .b    (b),
        .c    (c),
        .Done (Done),
        .z    (z),
        .x    (x)
    );

    // Reference: whole computation as plain 32-bit arithmetic.
    function automatic void model(input logic [31:0] ia, ib, ic,
                                  output logic [31:0] ox, oz);
        logic [31:0] d, e, f, g, h;
        bit          lt, eq;
        d  = ia + ib;
        e  = ia + ic;
        f  = ia - ib;
        lt = $signed(d) < $signed(e);
        eq = (d == e);
        g  = lt ? d : e;
        h  = eq ? g : f;
        ox = lt ? g * 32'd2 : g;
        oz = eq ? h / 32'd2 : h;
    endfunction

    // One computation from WAIT; optionally scrambles inputs and Start while busy.
    task automatic run_op(input logic [31:0] ia, ib, ic, input bit noise, input string name);
        logic [31:0] ex, ez;
        int          cnt;
        model(ia, ib, ic, ex, ez);
        @(negedge Clk);
        a = ia; b = ib; c = ic; Start = 1'b1;
        @(negedge Clk);
        Start = 1'b0;
        cnt   = 0;
        while (Done !== 1'b1 && cnt < 20) begin
            if (cnt <= 5) begin
                checks++;
                if (x !== exp_x) begin
                    failures++;
                    $display("FAIL %s x_hold cyc=%0d got=%h want=%h", name, cnt, x, exp_x);
                end
            end
            checks++;
            if (z !== exp_z) begin
                failures++;
                $display("FAIL %s z_hold cyc=%0d got=%h want=%h", name, cnt, z, exp_z);
            end
            if (noise) begin
                a = $urandom; b = $urandom; c = $urandom;
                Start = 1'($urandom_range(0, 1));
            end
            @(negedge Clk);
            cnt++;
        end
        Start = 1'b0;
        checks++;
        if (cnt !== 7) begin
            failures++;
            $display("FAIL %s latency got=%0d want=7", name, cnt);
        end
        exp_x = ex;
        exp_z = ez;
        checks++;
        if (x !== exp_x) begin
            failures++;
            $display("FAIL %s x got=%h want=%h", name, x, exp_x);
        end
        checks++;
        if (z !== exp_z) begin
            failures++;
            $display("FAIL %s z got=%h want=%h", name, z, exp_z);
        end
        @(negedge Clk);
        checks++;
        if (Done !== 1'b0) begin
            failures++;
            $display("FAIL %s done_width got=%b want=0", name, Done);
        end
        $display("run %s a=%h b=%h c=%h x=%h z=%h", name, ia, ib, ic, x, z);
    endtask

    task automatic test_reset();
        Rst = 1'b1; Start = 1'b0; a = '0; b = '0; c = '0;
        repeat (2) @(negedge Clk);
        checks++;
        if (Done !== 1'b0 || x !== 32'd0 || z !== 32'd0) begin
            failures++;
            $display("FAIL reset_state got done=%b x=%h z=%h want 0/0/0", Done, x, z);
        end
        Rst = 1'b0;
        @(negedge Clk);
        checks++;
        if (Done !== 1'b0) begin
            failures++;
            $display("FAIL reset_idle got done=%b want=0", Done);
        end
        $display("reset done x=%h z=%h", x, z);
    endtask

    task automatic test_vectors();
        run_op(32'd5, 32'd3, 32'd10, 1'b0, "v_lt");
        run_op(32'd5, 32'd7, 32'd7, 1'b0, "v_eq");
        run_op(32'd1, 32'd10, 32'd2, 1'b0, "v_gt");
        run_op(32'd0, 32'hFFFF_FFFF, 32'd1, 1'b0, "v_signed");
    endtask

    task automatic test_ignore_start();
        run_op(32'd5, 32'd3, 32'd10, 1'b1, "ignore_start");
        for (int i = 0; i < 10; i++) begin
            @(negedge Clk);
            checks++;
            if (Done !== 1'b0) begin
                failures++;
                $display("FAIL ignore_start extra_done cyc=%0d got=%b want=0", i, Done);
            end
        end
    endtask

    task automatic test_random();
        logic [31:0] ra, rb, rc;
        for (int i = 0; i < 24; i++) begin
            ra = $urandom; rb = $urandom; rc = $urandom;
            if ($urandom_range(0, 3) == 0) rc = rb;
            if ($urandom_range(0, 3) == 0) begin
                ra = $urandom_range(0, 40) - 20;
                rb = $urandom_range(0, 40) - 20;
            end
            run_op(ra, rb, rc, 1'(i % 2), "random");
        end
    endtask

    task automatic test_reset_mid();
        run_op(32'd5, 32'd3, 32'd10, 1'b0, "prior");
        @(negedge Clk);
        a = 32'd5; b = 32'd7; c = 32'd7; Start = 1'b1;
        @(negedge Clk);
        Start = 1'b0;
        repeat (4) @(negedge Clk);
        Rst = 1'b1; Start = 1'b1;
        #1;
        checks++;
        if (Done !== 1'b0 || x !== 32'd0 || z !== 32'd0) begin
            failures++;
            $display("FAIL reset_async got done=%b x=%h z=%h want 0/0/0", Done, x, z);
        end
        exp_x = '0;
        exp_z = '0;
        for (int i = 0; i < 3; i++) begin
            @(negedge Clk);
            checks++;
            if (Done !== 1'b0 || x !== 32'd0 || z !== 32'd0) begin
                failures++;
                $display("FAIL reset_hold cyc=%0d got done=%b x=%h z=%h want 0/0/0", i, Done, x, z);
            end
        end
        Rst = 1'b0; Start = 1'b0;
        @(negedge Clk);
        $display("reset_mid aborted x=%h z=%h", x, z);
        run_op(32'd5, 32'd7, 32'd7, 1'b0, "after_reset");
    endtask

    task automatic test_back_to_back();
        int n;
        @(negedge Clk);
        a = 32'd5; b = 32'd7; c = 32'd7; Start = 1'b1;
        n = 0;
        while (Done !== 1'b1 && n < 30) begin
            @(negedge Clk);
            n++;
        end
        checks++;
        if (n !== 8) begin
            failures++;
            $display("FAIL b2b first_latency got=%0d want=8", n);
        end
        for (int k = 0; k < 3; k++) begin
            n = 0;
            @(negedge Clk);
            n++;
            while (Done !== 1'b1 && n < 30) begin
                @(negedge Clk);
                n++;
            end
            checks++;
            if (n !== 9) begin
                failures++;
                $display("FAIL b2b period k=%0d got=%0d want=9", k, n);
            end
            checks++;
            if (x !== 32'd12 || z !== 32'd6) begin
                failures++;
                $display("FAIL b2b result k=%0d got x=%h z=%h want x=0000000c z=00000006", k, x, z);
            end
            $display("b2b pulse %0d gap=%0d x=%h z=%h", k, n, x, z);
        end
        Start = 1'b0;
        @(negedge Clk);
        checks++;
        if (Done !== 1'b0) begin
            failures++;
            $display("FAIL b2b stop got done=%b want=0", Done);
        end
        exp_x = 32'd12;
        exp_z = 32'd6;
    endtask

    initial begin
        test_reset();
        test_vectors();
        test_ignore_start();
        test_random();
        test_reset_mid();
        test_back_to_back();
        run_op(32'd1, 32'd10, 32'd2, 1'b0, "final");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
